// File: rtl/match_controller.sv
// Game-play sequencer for the tile-matching board: latches a generated map,
// runs two-pick turns, clears matched pairs and declares the win.
module match_controller #(
    parameter  int BLOCKS_WIDE    = 4,
    parameter  int BLOCKS_HIGH    = 4,
    parameter  int BITS_PER_BLOCK = 3,
    parameter  int HOLD_CYCLES    = 50000000,
    localparam int NUM_TILES      = BLOCKS_WIDE * BLOCKS_HIGH,
    localparam int IW             = $clog2(NUM_TILES),
    localparam int PW             = $clog2(NUM_TILES / 2 + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                gen_done,
    input  logic [NUM_TILES*BITS_PER_BLOCK-1:0] map_in,
    input  logic                                btn_up,
    input  logic                                btn_down,
    input  logic                                btn_left,
    input  logic                                btn_right,
    input  logic                                btn_select,
    input  logic                                new_game,
    output logic                                regen,
    output logic [NUM_TILES*BITS_PER_BLOCK-1:0] board,
    output logic [IW-1:0]                       cursor,
    output logic [NUM_TILES-1:0]                reveal_mask,
    output logic [IW-1:0]                       first_idx,
    output logic [IW-1:0]                       second_idx,
    output logic [PW-1:0]                       pairs_left,
    output logic [7:0]                          move_count,
    output logic                                game_won,
    output logic                                busy
);

    localparam int BW = $clog2(NUM_TILES * BITS_PER_BLOCK);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] FULL_PAIRS = PW'(NUM_TILES / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PICK1,
        S_PICK2,
        S_COMPARE,
        S_HOLD,
        S_WON
    } state_t;

    state_t                    state;
    logic [HW-1:0]             hold_cnt;
    logic [1:0]                ignore_cnt;
    logic [IW-1:0]             cursor_next;
    logic [BITS_PER_BLOCK-1:0] cursor_color;
    logic [BITS_PER_BLOCK-1:0] first_color;
    logic [BITS_PER_BLOCK-1:0] second_color;
    int                        row;
    int                        col;

    function automatic logic [BW-1:0] tile_base(input logic [IW-1:0] idx);
        return BW'(idx) * BW'(BITS_PER_BLOCK);
    endfunction

    assign cursor_color = board[tile_base(cursor)     +: BITS_PER_BLOCK];
    assign first_color  = board[tile_base(first_idx)  +: BITS_PER_BLOCK];
    assign second_color = board[tile_base(second_idx) +: BITS_PER_BLOCK];

    assign busy = (state == S_IDLE) || (state == S_LOAD) ||
                  (state == S_COMPARE) || (state == S_HOLD);

    // Wrapped cursor target for the highest-priority direction pulse this cycle.
    always_comb begin
        row         = int'(cursor) / BLOCKS_WIDE;
        col         = int'(cursor) % BLOCKS_WIDE;
        cursor_next = cursor;
        if (btn_up)
            cursor_next = IW'(((row == 0) ? BLOCKS_HIGH - 1 : row - 1) * BLOCKS_WIDE + col);
        else if (btn_down)
            cursor_next = IW'(((row == BLOCKS_HIGH - 1) ? 0 : row + 1) * BLOCKS_WIDE + col);
        else if (btn_left)
            cursor_next = IW'(row * BLOCKS_WIDE + ((col == 0) ? BLOCKS_WIDE - 1 : col - 1));
        else if (btn_right)
            cursor_next = IW'(row * BLOCKS_WIDE + ((col == BLOCKS_WIDE - 1) ? 0 : col + 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            board       <= '0;
            cursor      <= '0;
            reveal_mask <= '0;
            first_idx   <= '0;
            second_idx  <= '0;
            pairs_left  <= '0;
            move_count  <= '0;
            game_won    <= 1'b0;
            regen       <= 1'b0;
            hold_cnt    <= '0;
            ignore_cnt  <= '0;
        end else begin
            regen <= 1'b0;
            // ignore_cnt masks the generator's stale done flag while it restarts
            if (new_game && (state != S_IDLE) && (state != S_LOAD)) begin
                regen       <= 1'b1;
                reveal_mask <= '0;
                board       <= '0;
                game_won    <= 1'b0;
                hold_cnt    <= '0;
                ignore_cnt  <= 2'd2;
                state       <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ignore_cnt != 2'd0)
                            ignore_cnt <= ignore_cnt - 2'd1;
                        else if (gen_done)
                            state <= S_LOAD;
                    end
                    S_LOAD: begin
                        board       <= map_in;
                        pairs_left  <= FULL_PAIRS;
                        move_count  <= '0;
                        cursor      <= '0;
                        reveal_mask <= '0;
                        state       <= S_PICK1;
                    end
                    S_PICK1: begin
                        if (btn_select) begin
                            if (cursor_color != '0) begin
                                first_idx           <= cursor;
                                reveal_mask[cursor] <= 1'b1;
                                state               <= S_PICK2;
                            end
                        end else begin
                            cursor <= cursor_next;
                        end
                    end
                    S_PICK2: begin
                        if (btn_select) begin
                            if ((cursor_color != '0) && (cursor != first_idx)) begin
                                second_idx          <= cursor;
                                reveal_mask[cursor] <= 1'b1;
                                state               <= S_COMPARE;
                            end
                        end else begin
                            cursor <= cursor_next;
                        end
                    end
                    S_COMPARE: begin
                        if (move_count != 8'hFF)
                            move_count <= move_count + 8'd1;
                        if (first_color == second_color) begin
                            board[tile_base(first_idx)  +: BITS_PER_BLOCK] <= '0;
                            board[tile_base(second_idx) +: BITS_PER_BLOCK] <= '0;
                            reveal_mask[first_idx]  <= 1'b0;
                            reveal_mask[second_idx] <= 1'b0;
                            if (pairs_left != '0)
                                pairs_left <= pairs_left - PW'(1);
                            if (pairs_left == PW'(1)) begin
                                game_won <= 1'b1;
                                state    <= S_WON;
                            end else begin
                                state <= S_PICK1;
                            end
                        end else begin
                            hold_cnt <= HOLD_LOAD;
                            state    <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (hold_cnt == '0) begin
                            reveal_mask <= '0;
                            state       <= S_PICK1;
                        end else begin
                            hold_cnt <= hold_cnt - HW'(1);
                        end
                    end
                    S_WON: begin
                        game_won <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: a turn-level game model compared
// every cycle, plus hand-computed checkpoints along a scripted play-through.
module tb_match_controller;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int B    = 3;
    localparam int N    = W * H;
    localparam int HOLD = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           gen_done = 1'b0;
    logic [N*B-1:0] map_in = '0;
    logic           btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic           btn_right = 1'b0, btn_select = 1'b0, new_game = 1'b0;
    logic           regen;
    logic [N*B-1:0] board;
    logic [3:0]     cursor;
    logic [N-1:0]   reveal_mask;
    logic [3:0]     first_idx, second_idx;
    logic [3:0]     pairs_left;
    logic [7:0]     move_count;
    logic           game_won, busy;

    int checks = 0;
    int errors = 0;
    bit compare_on = 1'b0;

    int colors[N] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 5, 5, 6, 6, 6, 6};

    // Game model: tile colors, cursor row/col and the list of face-up picks.
    int m_tiles[N];
    int m_row, m_col;
    int picks[$];
    int m_first, m_second, m_pairs, m_moves, m_hold_left, m_idle_block;
    bit m_idle, m_loading, m_comparing, m_won, m_regen;

    match_controller #(
        .BLOCKS_WIDE   (W),
        .BLOCKS_HIGH   (H),
        .BITS_PER_BLOCK(B),
        .HOLD_CYCLES   (HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gen_done   (gen_done),
        .map_in     (map_in),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_select (btn_select),
        .new_game   (new_game),
        .regen      (regen),
        .board      (board),
        .cursor     (cursor),
        .reveal_mask(reveal_mask),
        .first_idx  (first_idx),
        .second_idx (second_idx),
        .pairs_left (pairs_left),
        .move_count (move_count),
        .game_won   (game_won),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N*B-1:0] pack_board();
        logic [N*B-1:0] r = '0;
        for (int i = N - 1; i >= 0; i--)
            r = (r << B) | (N*B)'(m_tiles[i] & 7);
        return r;
    endfunction

    function automatic logic [N-1:0] pack_mask();
        logic [N-1:0] r = '0;
        foreach (picks[k])
            r = r | (N'(1) << picks[k]);
        return r;
    endfunction

    function automatic int tile_of(input logic [N*B-1:0] b, input int t);
        return int'((b >> (t * B)) & (N*B)'(7));
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_tiles[i]) m_tiles[i] = 0;
        picks.delete();
        m_row = 0; m_col = 0; m_first = 0; m_second = 0;
        m_pairs = 0; m_moves = 0; m_hold_left = 0; m_idle_block = 0;
        m_idle = 1; m_loading = 0; m_comparing = 0; m_won = 0; m_regen = 0;
    endtask

    task automatic model_step();
        int c;
        m_regen = 0;
        if (new_game && !m_idle && !m_loading) begin
            m_regen = 1;
            picks.delete();
            foreach (m_tiles[i]) m_tiles[i] = 0;
            m_won = 0; m_idle = 1; m_idle_block = 2;
            m_comparing = 0; m_hold_left = 0;
        end else if (m_idle) begin
            if (m_idle_block > 0) m_idle_block--;
            else if (gen_done) begin m_idle = 0; m_loading = 1; end
        end else if (m_loading) begin
            for (int i = 0; i < N; i++) m_tiles[i] = tile_of(map_in, i);
            m_pairs = N / 2; m_moves = 0; m_row = 0; m_col = 0;
            picks.delete();
            m_loading = 0;
        end else if (m_comparing) begin
            m_comparing = 0;
            if (m_moves < 255) m_moves++;
            if (m_tiles[picks[0]] == m_tiles[picks[1]]) begin
                m_tiles[picks[0]] = 0;
                m_tiles[picks[1]] = 0;
                picks.delete();
                if (m_pairs > 0) m_pairs--;
                if (m_pairs == 0) m_won = 1;
            end else begin
                m_hold_left = HOLD;
            end
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) picks.delete();
        end else if (!m_won) begin
            c = m_row * W + m_col;
            if (btn_select) begin
                if (m_tiles[c] != 0 && (picks.size() == 0 || c != picks[0])) begin
                    picks.push_back(c);
                    if (picks.size() == 1) m_first = c;
                    else begin m_second = c; m_comparing = 1; end
                end
            end else if (btn_up)    m_row = (m_row + H - 1) % H;
            else if (btn_down)      m_row = (m_row + 1) % H;
            else if (btn_left)      m_col = (m_col + W - 1) % W;
            else if (btn_right)     m_col = (m_col + 1) % W;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge clk) begin
        if (compare_on) begin
            check_output("regen",       64'(regen),       64'(m_regen));
            check_output("board",       64'(board),       64'(pack_board()));
            check_output("cursor",      64'(cursor),      64'(m_row * W + m_col));
            check_output("reveal_mask", 64'(reveal_mask), 64'(pack_mask()));
            check_output("first_idx",   64'(first_idx),   64'(m_first));
            check_output("second_idx",  64'(second_idx),  64'(m_second));
            check_output("pairs_left",  64'(pairs_left),  64'(m_pairs));
            check_output("move_count",  64'(move_count),  64'(m_moves));
            check_output("game_won",    64'(game_won),    64'(m_won));
            check_output("busy",        64'(busy),
                         64'(m_idle || m_loading || m_comparing || m_hold_left > 0));
        end
    end

    task automatic apply_stimulus(input bit sel, input bit up, input bit down,
                                  input bit left, input bit right, input bit ng);
        btn_select = sel; btn_up = up; btn_down = down;
        btn_left = left; btn_right = right; new_game = ng;
        @(negedge clk);
        btn_select = 0; btn_up = 0; btn_down = 0;
        btn_left = 0; btn_right = 0; new_game = 0;
    endtask

    task automatic move_to(input int target);
        for (int g = 0; g < H && m_row != target / W; g++) apply_stimulus(0, 0, 1, 0, 0, 0);
        for (int g = 0; g < W && m_col != target % W; g++) apply_stimulus(0, 0, 0, 0, 1, 0);
    endtask

    // new_game with gen_done held high: one regen pulse, two blind idle cycles, reload.
    task automatic new_game_sequence(input bit with_select);
        apply_stimulus(with_select, 0, 0, 0, 0, 1);
        check_output("ng_regen_hi",  64'(regen),       64'd1);
        check_output("ng_board_clr", 64'(board),       64'd0);
        check_output("ng_mask_clr",  64'(reveal_mask), 64'd0);
        check_output("ng_won_clr",   64'(game_won),    64'd0);
        @(negedge clk);
        check_output("ng_regen_lo",  64'(regen),       64'd0);
        @(negedge clk);
        check_output("ng_no_load",   64'(board),       64'd0);
        @(negedge clk);
        check_output("ng_in_load",   64'(board),       64'd0);
        @(negedge clk);
        check_output("ng_reloaded",  64'(board),       64'(map_in));
        check_output("ng_busy_lo",   64'(busy),        64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = N - 1; i >= 0; i--)
            map_in = (map_in << B) | (N*B)'(colors[i]);
        reset = 1;
        repeat (2) @(negedge clk);
        compare_on = 1;
        check_output("rst_board", 64'(board),  64'd0);
        check_output("rst_busy",  64'(busy),   64'd1);
        reset = 0;
        repeat (3) @(negedge clk);
        check_output("idle_wait_busy", 64'(busy), 64'd1);
        gen_done = 1;
        @(negedge clk);
        gen_done = 0;
        @(negedge clk);
        check_output("load_board", 64'(board),      64'(map_in));
        check_output("load_pairs", 64'(pairs_left), 64'd8);

        // Cursor wrap and direction priority
        apply_stimulus(0, 0, 0, 1, 0, 0); check_output("wrap_left",  64'(cursor), 64'd3);
        apply_stimulus(0, 1, 0, 0, 0, 0); check_output("wrap_up",    64'(cursor), 64'd15);
        apply_stimulus(0, 0, 0, 0, 1, 0); check_output("wrap_right", 64'(cursor), 64'd12);
        apply_stimulus(0, 0, 1, 0, 0, 0); check_output("wrap_down",  64'(cursor), 64'd0);
        apply_stimulus(0, 1, 0, 1, 0, 0); check_output("up_beats_left", 64'(cursor), 64'd12);
        apply_stimulus(0, 0, 1, 0, 0, 0);

        // Mismatch: tile 0 (color 1) against tile 2 (color 2)
        apply_stimulus(1, 0, 0, 0, 0, 0);
        move_to(2);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_output("cmp_mask", 64'(reveal_mask), 64'h5);
        for (int k = 1; k <= HOLD; k++) begin
            if (k == 3) apply_stimulus(1, 0, 0, 0, 0, 0);
            else        @(negedge clk);
            check_output("hold_mask", 64'(reveal_mask), 64'h5);
            check_output("hold_busy", 64'(busy),        64'd1);
        end
        @(negedge clk);
        check_output("post_hold_mask",  64'(reveal_mask), 64'h0);
        check_output("post_hold_moves", 64'(move_count),  64'd1);
        check_output("post_hold_board", 64'(board),       64'(map_in));

        // Illegal picks: reselect first in PICK2, then a cleared tile in PICK1
        move_to(0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_output("reselect_mask", 64'(reveal_mask), 64'h1);
        check_output("reselect_busy", 64'(busy),        64'd0);
        move_to(1);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("match_t0",    64'(tile_of(board, 0)), 64'd0);
        check_output("match_t1",    64'(tile_of(board, 1)), 64'd0);
        check_output("match_pairs", 64'(pairs_left),        64'd7);
        check_output("match_moves", 64'(move_count),        64'd2);
        apply_stimulus(0, 0, 0, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_output("cleared_pick_mask", 64'(reveal_mask), 64'h0);
        move_to(2);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_output("pick_after_clear", 64'(reveal_mask), 64'h4);

        // Reset asynchronously in the middle of HOLD
        move_to(4);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1;
        #1;
        check_output("arst_board", 64'(board),       64'd0);
        check_output("arst_mask",  64'(reveal_mask), 64'd0);
        check_output("arst_cur",   64'(cursor),      64'd0);
        check_output("arst_first", 64'(first_idx),   64'd0);
        check_output("arst_sec",   64'(second_idx),  64'd0);
        check_output("arst_pairs", 64'(pairs_left),  64'd0);
        check_output("arst_moves", 64'(move_count),  64'd0);
        check_output("arst_won",   64'(game_won),    64'd0);
        check_output("arst_regen", 64'(regen),       64'd0);
        check_output("arst_busy",  64'(busy),        64'd1);
        @(negedge clk);
        reset = 0;
        gen_done = 1;
        repeat (2) @(negedge clk);
        check_output("reload_board", 64'(board),      64'(map_in));
        check_output("reload_pairs", 64'(pairs_left), 64'd8);
        check_output("reload_moves", 64'(move_count), 64'd0);

        // Win path: every equal neighbour pair in turn
        for (int k = 0; k < N / 2; k++) begin
            move_to(2 * k);
            apply_stimulus(1, 0, 0, 0, 0, 0);
            move_to(2 * k + 1);
            apply_stimulus(1, 0, 0, 0, 0, 0);
            @(negedge clk);
            check_output("win_tile_a", 64'(tile_of(board, 2 * k)),     64'd0);
            check_output("win_tile_b", 64'(tile_of(board, 2 * k + 1)), 64'd0);
            check_output("win_pairs",  64'(pairs_left), 64'(7 - k));
        end
        check_output("won_flag",  64'(game_won),   64'd1);
        check_output("won_moves", 64'(move_count), 64'd8);
        check_output("won_board", 64'(board),      64'd0);
        check_output("won_busy",  64'(busy),       64'd0);

        // new_game from WON, then from PICK2 together with a select
        new_game_sequence(0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_output("pick2_mask", 64'(reveal_mask), 64'h1);
        new_game_sequence(1);

        gen_done = 0;
        repeat (2) @(negedge clk);
        compare_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Game-play sequencer for the tile-matching board.
- Waits for the map generator's done flag, then latches the generated color map into a working board.
- Moves the cursor, reveals two picks and compares them; clears matched pairs or holds mismatches visible for a fixed time.
- Tracks moves and pairs remaining, declares the win, and requests a fresh map on new_game.

Parameters:
- BLOCKS_WIDE, 4, tiles per row
- BLOCKS_HIGH, 4, tiles per column
- BITS_PER_BLOCK, 3, bits per tile color code (0 = empty, 1..6 = colors)
- HOLD_CYCLES, 50000000, cycles a mismatched pair stays revealed (must be >= 1)
- Derived, not overridable: NUM_TILES = BLOCKS_WIDE*BLOCKS_HIGH; IW = clog2(NUM_TILES); PW = clog2(NUM_TILES/2+1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- gen_done  in  1  map generator finished (level)
- map_in  in  NUM_TILES*BITS_PER_BLOCK  generated map; tile i at bits [i*BITS_PER_BLOCK +: BITS_PER_BLOCK]
- btn_up, btn_down, btn_left, btn_right, btn_select  in  1 each  single-cycle debounced pulses
- new_game  in  1  single-cycle pulse
- regen  out  1  one-cycle pulse requesting the map generator to reset/regenerate
- board  out  NUM_TILES*BITS_PER_BLOCK  working board, same packing as map_in
- cursor  out  IW  tile index = row*BLOCKS_WIDE + col
- reveal_mask  out  NUM_TILES  tiles currently shown face-up as picks
- first_idx, second_idx  out  IW each  current picks
- pairs_left  out  PW  unmatched pairs remaining
- move_count  out  8  completed comparisons, saturating at 255
- game_won  out  1  high in WON state
- busy  out  1  high in IDLE, LOAD, COMPARE, HOLD (input ignored)

Behaviour:
- Reset (async) values: state IDLE; board 0; cursor 0; reveal_mask 0; first_idx/second_idx 0; pairs_left 0; move_count 0; game_won 0; regen 0; hold counter 0. A reset mid-HOLD or mid-COMPARE abandons the turn immediately.
- States: IDLE, LOAD, PICK1, PICK2, COMPARE, HOLD, WON.
- IDLE: wait for gen_done=1, then go to LOAD.
- LOAD (1 cycle): board <= map_in; pairs_left <= NUM_TILES/2; move_count <= 0; cursor <= 0; go to PICK1.
- Cursor moves in PICK1/PICK2 only, one action per cycle.
  - Priority: select > up > down > left > right; lower-priority pulses in the same cycle are dropped.
  - Up/down wrap within the column (row 0 up goes to row BLOCKS_HIGH-1).
  - Left/right wrap within the row (col 0 left goes to col BLOCKS_WIDE-1).
  - A select cycle does not move the cursor.
- PICK1 select:
  - Ignored if board[cursor]==0.
  - Otherwise first_idx <= cursor, reveal_mask[cursor] <= 1, go to PICK2.
- PICK2 select:
  - Ignored if board[cursor]==0 or cursor==first_idx.
  - Otherwise second_idx <= cursor, reveal bit set, go to COMPARE.
- COMPARE (exactly 1 cycle; result visible 2 cycles after the accepted second select):
  - move_count increments, saturating at 255.
  - Colors equal: both board tiles <= 0, both reveal bits cleared, pairs_left decrements. Go to WON if pairs_left was 1, else PICK1.
  - Colors differ: load hold counter, go to HOLD.
- HOLD:
  - Stays exactly HOLD_CYCLES cycles.
  - On exit, reveal_mask <= 0 and go to PICK1.
  - Button pulses during HOLD are discarded, not queued.
- WON: game_won=1; board is all zero; stays until reset or new_game.
- new_game, accepted in any state except IDLE and LOAD (ignored there):
  - regen pulses for 1 cycle; reveal_mask, board and game_won clear; go to IDLE.
  - new_game beats every other input in the same cycle.
  - IDLE ignores gen_done in the cycle regen is high and the next cycle, so a stale done flag is not accepted.
- pairs_left never underflows. A generated map with an odd color count is a generator fault; the controller does not check for it.

Test Plan:
- Win path: gen_done=1 with map colors [1,1,2,2,3,3,4,4,5,5,5,5,6,6,6,6]; pick every equal pair in turn -> each pair's tiles read 0 two cycles after the second select; pairs_left counts 8 down to 0; game_won=1 after the 8th pair; move_count=8.
- Mismatch: pick tile 0 (color 1) then tile 2 (color 2) with HOLD_CYCLES=5 -> reveal_mask=0x0005 for COMPARE plus 5 HOLD cycles, then 0 in PICK1; board unchanged; move_count=1; a select pulsed during HOLD has no effect.
- Cursor wrap: from cursor 0, left -> 3; up -> 15; right -> 12; down -> 0. Same-cycle up+left -> up only applied.
- Illegal picks: select an already-cleared tile in PICK1 -> stays PICK1, reveal_mask 0. Reselect first_idx in PICK2 -> stays PICK2.
- Reset mid-HOLD: assert reset asynchronously between clock edges -> all outputs return to their reset values immediately; after release with gen_done=1, LOAD reloads map_in.
- new_game in PICK2 -> regen high for exactly 1 cycle; board 0; state IDLE; gen_done held high does not trigger LOAD for 2 cycles.
